pu_accum: RTL and testbench



---
 rtl/pu_accum.sv | 86 ++++++++
 tb/tb_pu_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pu_accum.sv
// pu_accum: signed accumulator PU on the NITTA data bus.
// Each load adds the bus word to the accumulator, or subtracts it when
// signal_neg is set. The invalid flag on incoming words is carried into the
// result, and a sticky flag records signed overflow.
// The outputs are zero unless signal_oe is high, so the outputs of all PUs
// can be OR-combined onto the shared bus.
module pu_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = 0,
  parameter int OVERFLOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_init,
  input  logic                  signal_load,
  input  logic                  signal_neg,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_inv_flag;
  logic                  r_ovf_flag;

  logic [DATA_WIDTH-1:0] w_term;
  logic                  w_neg_ovf;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_sum_ovf;
  logic                  w_unused_attr;

  // Negating MIN wraps back to MIN in DATA_WIDTH bits. That case is reported as an overflow event.
  assign w_neg_ovf = signal_neg && (data_in == MIN_VAL);
  assign w_term    = signal_neg ? (~data_in + 1'b1) : data_in;

  // Sign-extend both operands by one bit. A signed overflow then shows up as
  // a disagreement between the top two bits of the sum.
  assign w_sum     = {r_acc[DATA_WIDTH-1], r_acc} + {w_term[DATA_WIDTH-1], w_term};
  assign w_sum_ovf = w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1];

  // Only the INVALID bit of attr_in carries meaning here; the other bits are deliberately dropped.
  assign w_unused_attr = ^attr_in;

  // Accumulator state: reset, then start, then add to the running sum, then clear without a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_inv_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else if (signal_load && signal_init) begin
      r_acc      <= w_term;
      r_inv_flag <= attr_in[INVALID];
      r_ovf_flag <= w_neg_ovf;
    end else if (signal_load) begin
      r_acc      <= w_sum[DATA_WIDTH-1:0];
      r_inv_flag <= r_inv_flag | attr_in[INVALID];
      r_ovf_flag <= r_ovf_flag | w_neg_ovf | w_sum_ovf;
    end else if (signal_init) begin
      r_acc      <= '0;
      r_inv_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end
  end

  // A bus read has no side effects. The output is gated to zero when the unit is not selected.
  assign data_out = signal_oe ? r_acc : '0;

  // Only the INVALID and OVERFLOW attribute positions can be non-zero.
  generate
    for (genvar gi = 0; gi < ATTR_WIDTH; gi++) begin : g_attr
      if (gi == INVALID) begin : g_inv
        assign attr_out[gi] = signal_oe & r_inv_flag;
      end else if (gi == OVERFLOW) begin : g_ovf
        assign attr_out[gi] = signal_oe & r_ovf_flag;
      end else begin : g_zero
        assign attr_out[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pu_accum.sv
// Directed testbench for pu_accum. Each task drives one scenario and checks
// the bus against expected values worked out by hand.
module tb_pu_accum;

  logic        clk;
  logic        rst;
  logic        signal_init;
  logic        signal_load;
  logic        signal_neg;
  logic        signal_oe;
  logic [31:0] data_in;
  logic [3:0]  attr_in;
  logic [31:0] data_out;
  logic [3:0]  attr_out;

  int errors = 0;
  int checks = 0;

  pu_accum #(
    .DATA_WIDTH(32),
    .ATTR_WIDTH(4),
    .INVALID(0),
    .OVERFLOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_init(signal_init),
    .signal_load(signal_load),
    .signal_neg (signal_neg),
    .signal_oe  (signal_oe),
    .data_in    (data_in),
    .attr_in    (attr_in),
    .data_out   (data_out),
    .attr_out   (attr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the controls 1 time unit after a rising edge, so the inputs are
  // sampled at the next edge. Outputs are then observed 2 time units after
  // that edge.
  task automatic step(input logic r, input logic i, input logic l, input logic n,
                      input logic o, input logic [31:0] d, input logic [3:0] a);
    @(posedge clk);
    #1;
    rst = r; signal_init = i; signal_load = l; signal_neg = n; signal_oe = o;
    data_in = d; attr_in = a;
    #1;
    $display("txn rst=%0b init=%0b load=%0b neg=%0b oe=%0b din=%h ain=%b -> dout=%h aout=%b",
             r, i, l, n, o, d, a, data_out, attr_out);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL reset_oe0: got %h/%b want 0/0", data_out, attr_out);
    end
    step(1, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL reset_during_oe1: got %h/%b want 0/0", data_out, attr_out);
    end
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL reset_after_oe1: got %h/%b want 0/0", data_out, attr_out);
    end
  endtask

  task automatic test_sequence();
    step(0, 1, 1, 0, 0, 32'd5, 4'd0);
    step(0, 0, 1, 0, 1, 32'd7, 4'd0);
    checks++;
    if (data_out !== 32'd5) begin
      errors++; $display("FAIL seq_after_init5: got %h want 5", data_out);
    end
    step(0, 0, 1, 1, 1, 32'd3, 4'd0);
    checks++;
    if (data_out !== 32'd12) begin
      errors++; $display("FAIL seq_after_add7: got %h want 12", data_out);
    end
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd9 || attr_out !== 4'd0) begin
      errors++; $display("FAIL seq_result: got %h/%b want 9/0000", data_out, attr_out);
    end
    // Reading again must return the same value, and neg without load must change nothing.
    step(0, 0, 0, 1, 1, 32'd100, 4'd0);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd9) begin
      errors++; $display("FAIL seq_nondestructive: got %h want 9", data_out);
    end
    step(0, 0, 0, 0, 0, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL seq_oe0_gated: got %h/%b want 0/0", data_out, attr_out);
    end
  endtask

  task automatic test_overflow();
    step(0, 1, 1, 0, 0, 32'h7FFF_FFFF, 4'd0);
    step(0, 0, 1, 0, 1, 32'd1, 4'd0);
    checks++;
    if (data_out !== 32'h7FFF_FFFF || attr_out !== 4'd0) begin
      errors++; $display("FAIL ovf_before: got %h/%b want 7fffffff/0000", data_out, attr_out);
    end
    step(0, 0, 1, 1, 1, 32'd1, 4'd0);
    checks++;
    if (data_out !== 32'h8000_0000 || attr_out !== 4'b0010) begin
      errors++; $display("FAIL ovf_wrap: got %h/%b want 80000000/0010", data_out, attr_out);
    end
    step(0, 1, 1, 0, 1, 32'd2, 4'd0);
    checks++;
    if (data_out !== 32'h7FFF_FFFF || attr_out !== 4'b0010) begin
      errors++; $display("FAIL ovf_sticky: got %h/%b want 7fffffff/0010", data_out, attr_out);
    end
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd2 || attr_out !== 4'd0) begin
      errors++; $display("FAIL ovf_init_clears: got %h/%b want 2/0000", data_out, attr_out);
    end
  endtask

  task automatic test_invalid();
    step(0, 1, 1, 0, 0, 32'd10, 4'b0001);
    step(0, 0, 1, 0, 1, 32'd4, 4'b0000);
    checks++;
    if (data_out !== 32'd10 || attr_out !== 4'b0001) begin
      errors++; $display("FAIL inv_first: got %h/%b want a/0001", data_out, attr_out);
    end
    step(0, 1, 1, 0, 1, 32'd1, 4'b1110);
    checks++;
    if (data_out !== 32'd14 || attr_out !== 4'b0001) begin
      errors++; $display("FAIL inv_propagate: got %h/%b want e/0001", data_out, attr_out);
    end
    step(0, 1, 1, 1, 1, 32'h8000_0000, 4'd0);
    checks++;
    if (data_out !== 32'd1 || attr_out !== 4'b0000) begin
      errors++; $display("FAIL inv_other_bits_ignored: got %h/%b want 1/0000", data_out, attr_out);
    end
    step(0, 1, 1, 1, 1, 32'd6, 4'd0);
    checks++;
    if (data_out !== 32'h8000_0000 || attr_out !== 4'b0010) begin
      errors++; $display("FAIL neg_min: got %h/%b want 80000000/0010", data_out, attr_out);
    end
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'hFFFF_FFFA || attr_out !== 4'b0000) begin
      errors++; $display("FAIL neg_init6: got %h/%b want fffffffa/0000", data_out, attr_out);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 1, 0, 0, 32'd20, 4'd0);
    step(0, 0, 1, 0, 1, 32'd1, 4'd0);
    checks++;
    if (data_out !== 32'd20) begin
      errors++; $display("FAIL sim_load_oe_pre: got %h want 14", data_out);
    end
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd21) begin
      errors++; $display("FAIL sim_load_oe_post: got %h want 15", data_out);
    end
    step(1, 0, 1, 0, 0, 32'd99, 4'b0001);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL sim_rst_load: got %h/%b want 0/0000", data_out, attr_out);
    end
    // After a reset, a plain load adds to zero.
    step(0, 0, 1, 0, 0, 32'd5, 4'd0);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd5) begin
      errors++; $display("FAIL sim_load_after_rst: got %h want 5", data_out);
    end
  endtask

  task automatic test_init_clear();
    // MIN plus (MIN+21) wraps to 21 with an overflow. The negated MIN also sets the flag.
    step(0, 1, 1, 1, 0, 32'h8000_0000, 4'd0);
    step(0, 0, 1, 0, 0, 32'h8000_0015, 4'd0);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd21 || attr_out !== 4'b0010) begin
      errors++; $display("FAIL clr_setup: got %h/%b want 15/0010", data_out, attr_out);
    end
    step(0, 1, 0, 0, 0, 32'd0, 4'd0);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd0 || attr_out !== 4'd0) begin
      errors++; $display("FAIL clr_init_only: got %h/%b want 0/0000", data_out, attr_out);
    end
    step(0, 0, 1, 0, 0, 32'd3, 4'd0);
    step(0, 0, 0, 0, 1, 32'd0, 4'd0);
    checks++;
    if (data_out !== 32'd3 || attr_out !== 4'd0) begin
      errors++; $display("FAIL clr_then_load: got %h/%b want 3/0000", data_out, attr_out);
    end
  endtask

  initial begin
    rst = 1'b1; signal_init = 1'b0; signal_load = 1'b0; signal_neg = 1'b0;
    signal_oe = 1'b0; data_in = '0; attr_in = '0;
    test_reset();
    test_sequence();
    test_overflow();
    test_invalid();
    test_simultaneous();
    test_init_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
